// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: N-way set-associative, write-back, write-allocate
// cache controller with internal tag/data arrays and round-robin victims.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   cpu_req/we/addr/wdata        CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack, cpu_busy CPU response, one-cycle ack, busy flag
//   mem_req/we/addr/wdata        byte-serial memory burst, one beat/cycle
//   mem_rdata, mem_ready         fill byte, beat transfers when ready
//   hit_cnt, miss_cnt            saturating counters (PERF_CNT_EN)
//
// Optional feature macro: PERF_CNT_EN (counters; tied to 0 otherwise).
module assoc_cache_ctrl #(
    parameter int AWIDTH      = 16,
    parameter int DWIDTH      = 8,
    parameter int WAYS        = 2,
    parameter int SETS        = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic [DWIDTH-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int OFFW = $clog2(BLOCK_BYTES);
    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = AWIDTH - IDXW - OFFW;
    localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WBACK,
        FILL,
        RESP
    } state_t;

    state_t state, state_n;

    logic [AWIDTH-1:0] q_addr;
    logic              q_we;
    logic [DWIDTH-1:0] q_wdata;

    logic [SETS-1:0]   valid [WAYS];
    logic [SETS-1:0]   dirty [WAYS];
    logic [TAGW-1:0]   tags  [WAYS][SETS];
    logic [DWIDTH-1:0] data  [WAYS][SETS][BLOCK_BYTES];
    logic [WAYW-1:0]   rr_ptr [SETS];

    logic [OFFW-1:0]   beat;
    logic [WAYW-1:0]   victim;
    logic              victim_rr;
    logic [TAGW-1:0]   victim_tag;
    // gap holds mem_req low for one cycle between write-back and fill
    logic              gap;
    // refill marks the re-lookup after a fill so it is not counted
    logic              refill;

    logic [TAGW-1:0]   q_tag;
    logic [IDXW-1:0]   q_idx;
    logic [OFFW-1:0]   q_off;

    logic              hit;
    logic [WAYW-1:0]   hit_way;
    logic              inv_found;
    logic [WAYW-1:0]   inv_way;
    logic [WAYW-1:0]   pick_way;
    logic              last_beat;
    logic              xfer;

    assign q_tag = q_addr[AWIDTH-1 -: TAGW];
    assign q_idx = q_addr[OFFW +: IDXW];
    assign q_off = q_addr[OFFW-1:0];

    assign last_beat = (beat == OFFW'(BLOCK_BYTES - 1));
    assign xfer      = mem_req && mem_ready;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid[w][q_idx] && tags[w][q_idx] == q_tag) begin
                hit     = 1'b1;
                hit_way = WAYW'(w);
            end
            if (!inv_found && !valid[w][q_idx]) begin
                inv_found = 1'b1;
                inv_way   = WAYW'(w);
            end
        end
        pick_way = inv_found ? inv_way : rr_ptr[q_idx];
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == WBACK) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {victim_tag, q_idx, beat};
            mem_wdata = data[victim][q_idx][beat];
        end else if (state == FILL && !gap) begin
            mem_req  = 1'b1;
            mem_addr = {q_tag, q_idx, beat};
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (cpu_req && !cpu_busy)
                    state_n = LOOKUP;
            end
            LOOKUP: begin
                if (hit)
                    state_n = RESP;
                else if (valid[pick_way][q_idx] && dirty[pick_way][q_idx])
                    state_n = WBACK;
                else
                    state_n = FILL;
            end
            WBACK: begin
                if (xfer && last_beat)
                    state_n = FILL;
            end
            FILL: begin
                if (xfer && last_beat)
                    state_n = LOOKUP;
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            q_addr     <= '0;
            q_we       <= 1'b0;
            q_wdata    <= '0;
            cpu_rdata  <= '0;
            cpu_ack    <= 1'b0;
            cpu_busy   <= 1'b0;
            beat       <= '0;
            victim     <= '0;
            victim_rr  <= 1'b0;
            victim_tag <= '0;
            gap        <= 1'b0;
            refill     <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                valid[w] <= '0;
                dirty[w] <= '0;
            end
            for (int s = 0; s < SETS; s++)
                rr_ptr[s] <= '0;
        end else begin
            state   <= state_n;
            cpu_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_busy) begin
                        cpu_busy <= 1'b0;
                    end else if (cpu_req) begin
                        q_addr   <= cpu_addr;
                        q_we     <= cpu_we;
                        q_wdata  <= cpu_wdata;
                        cpu_busy <= 1'b1;
                        refill   <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (q_we)
                            dirty[hit_way][q_idx] <= 1'b1;
                        else
                            cpu_rdata <= data[hit_way][q_idx][q_off];
                    end else begin
                        victim     <= pick_way;
                        victim_rr  <= !inv_found;
                        victim_tag <= tags[pick_way][q_idx];
                        beat       <= '0;
                    end
                end
                WBACK: begin
                    if (xfer) begin
                        beat <= beat + 1'b1;
                        if (last_beat)
                            gap <= 1'b1;
                    end
                end
                FILL: begin
                    gap <= 1'b0;
                    if (xfer) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            valid[victim][q_idx] <= 1'b1;
                            dirty[victim][q_idx] <= 1'b0;
                            refill <= 1'b1;
                            if (victim_rr)
                                rr_ptr[q_idx] <=
                                    (rr_ptr[q_idx] == WAYW'(WAYS - 1)) ?
                                    '0 : rr_ptr[q_idx] + 1'b1;
                        end
                    end
                end
                RESP: cpu_ack <= 1'b1;
                default: ;
            endcase
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them.
    always_ff @(posedge clock) begin
        if (state == LOOKUP && hit && q_we)
            data[hit_way][q_idx][q_off] <= q_wdata;
        if (state == FILL && xfer) begin
            data[victim][q_idx][beat] <= mem_rdata;
            if (last_beat)
                tags[victim][q_idx] <= q_tag;
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit && !refill && hit_cnt != 16'hFFFF)
                hit_cnt <= hit_cnt + 16'd1;
            if (!hit && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// tb_assoc_cache_ctrl: directed self-checking bench for assoc_cache_ctrl
// with a byte-array memory model and a transfer log.
module tb_assoc_cache_ctrl;

    logic        clock;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        cpu_busy;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int checks;
    int errors;

    logic [7:0]  mem [65536];
    logic [24:0] xlog [$];

    assoc_cache_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_busy  (cpu_busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clock) begin
        if (mem_req && mem_ready) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                xlog.push_back({1'b1, mem_addr, mem_wdata});
            end else begin
                xlog.push_back({1'b0, mem_addr, mem_rdata});
            end
        end
    end

    task automatic cpu_op(
        input  logic        we,
        input  logic [15:0] addr,
        input  logic [7:0]  wd,
        output logic [7:0]  rd,
        output int          cyc,
        output logic        ack2,
        output logic        busy2,
        output int          bursts
    );
        logic prev;
        bit   done;
        @(negedge clock);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cyc    = 0;
        bursts = 0;
        prev   = 1'b0;
        rd     = '0;
        done   = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (mem_req && !prev)
                bursts++;
            prev = mem_req;
            if (cpu_ack) begin
                done = 1'b1;
                rd   = cpu_rdata;
            end
        end
        cpu_req = 1'b0;
        if (!done)
            cyc = -1;
        @(negedge clock);
        ack2  = cpu_ack;
        busy2 = cpu_busy;
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ready = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({cpu_ack, cpu_busy, mem_req, mem_we} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 0000",
                     {cpu_ack, cpu_busy, mem_req, mem_we});
        end
        checks++;
        if ({mem_addr, mem_wdata, cpu_rdata} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0",
                     {mem_addr, mem_wdata, cpu_rdata});
        end
        checks++;
        if ({hit_cnt, miss_cnt} !== 32'h0) begin
            errors++;
            $display("FAIL reset_cnt got %h want 0", {hit_cnt, miss_cnt});
        end
        reset = 1'b1;
    endtask

    task automatic test_read_miss;
        logic [7:0] rd;
        int cyc, bursts;
        logic a2, b2;
        logic [24:0] exp;
        xlog.delete();
        cpu_op(1'b0, 16'h0010, 8'h00, rd, cyc, a2, b2, bursts);
        checks++;
        if (rd !== 8'h10) begin
            errors++;
            $display("FAIL miss_rdata got %h want 10", rd);
        end
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL miss_latency got %0d want 8", cyc);
        end
        checks++;
        if ({a2, b2, bursts[1:0]} !== 4'b0001) begin
            errors++;
            $display("FAIL miss_ack_pulse got %b want 0001",
                     {a2, b2, bursts[1:0]});
        end
        checks++;
        if (xlog.size() != 4) begin
            errors++;
            $display("FAIL miss_beats got %0d want 4", xlog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp = {1'b0, 16'h0010 + 16'(i), 8'h10 + 8'(i)};
                checks++;
                if (xlog[i] !== exp) begin
                    errors++;
                    $display("FAIL miss_beat%0d got %h want %h",
                             i, xlog[i], exp);
                end
            end
        end
    endtask

    task automatic test_write_hit;
        logic [7:0] rd;
        int cyc, bursts;
        logic a2, b2;
        xlog.delete();
        cpu_op(1'b1, 16'h0011, 8'hAB, rd, cyc, a2, b2, bursts);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL whit_latency got %0d want 3", cyc);
        end
        checks++;
        if (bursts != 0 || xlog.size() != 0) begin
            errors++;
            $display("FAIL whit_nomem got %0d/%0d want 0/0",
                     bursts, xlog.size());
        end
        cpu_op(1'b0, 16'h0011, 8'h00, rd, cyc, a2, b2, bursts);
        checks++;
        if (rd !== 8'hAB) begin
            errors++;
            $display("FAIL rhit_rdata got %h want ab", rd);
        end
        checks++;
        if (cyc != 3 || bursts != 0) begin
            errors++;
            $display("FAIL rhit_latency got %0d/%0d want 3/0", cyc, bursts);
        end
        checks++;
        if ({a2, b2} !== 2'b00) begin
            errors++;
            $display("FAIL rhit_after got %b want 00", {a2, b2});
        end
    endtask

    task automatic test_perf;
        logic [15:0] eh, em;
`ifdef PERF_CNT_EN
        eh = 16'd2;
        em = 16'd1;
`else
        eh = 16'd0;
        em = 16'd0;
`endif
        checks++;
        if (hit_cnt !== eh || miss_cnt !== em) begin
            errors++;
            $display("FAIL perf_cnt got %0d/%0d want %0d/%0d",
                     hit_cnt, miss_cnt, eh, em);
        end
    endtask

    task automatic test_evict;
        logic [7:0] rd;
        int cyc, bursts;
        logic a2, b2;
        logic [7:0] wb [4];
        logic [24:0] exp;
        wb[0] = 8'h10;
        wb[1] = 8'hAB;
        wb[2] = 8'h12;
        wb[3] = 8'h13;
        cpu_op(1'b0, 16'h0030, 8'h00, rd, cyc, a2, b2, bursts);
        checks++;
        if (rd !== 8'h30 || cyc != 8) begin
            errors++;
            $display("FAIL evict_fill30 got %h/%0d want 30/8", rd, cyc);
        end
        xlog.delete();
        cpu_op(1'b0, 16'h0050, 8'h00, rd, cyc, a2, b2, bursts);
        checks++;
        if (rd !== 8'h50) begin
            errors++;
            $display("FAIL evict_rdata got %h want 50", rd);
        end
        checks++;
        if (cyc != 13 || bursts != 2) begin
            errors++;
            $display("FAIL evict_timing got %0d/%0d want 13/2", cyc, bursts);
        end
        checks++;
        if (xlog.size() != 8) begin
            errors++;
            $display("FAIL evict_beats got %0d want 8", xlog.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (i < 4)
                    exp = {1'b1, 16'h0010 + 16'(i), wb[i]};
                else
                    exp = {1'b0, 16'h0050 + 16'(i - 4), 8'h50 + 8'(i - 4)};
                checks++;
                if (xlog[i] !== exp) begin
                    errors++;
                    $display("FAIL evict_beat%0d got %h want %h",
                             i, xlog[i], exp);
                end
            end
        end
    endtask

    task automatic test_stall;
        logic [7:0] rd;
        int cyc, bursts;
        logic a2, b2;
        xlog.delete();
        fork
            cpu_op(1'b0, 16'h0070, 8'h00, rd, cyc, a2, b2, bursts);
            begin
                int  n;
                bit  seen;
                n    = 0;
                seen = 1'b0;
                while (!seen && n < 100) begin
                    @(negedge clock);
                    n++;
                    if (mem_req && mem_addr == 16'h0072)
                        seen = 1'b1;
                end
                checks++;
                if (!seen) begin
                    errors++;
                    $display("FAIL stall_reach got 0 want 1");
                end else begin
                    mem_ready = 1'b0;
                    repeat (5) begin
                        @(negedge clock);
                        checks++;
                        if (mem_addr !== 16'h0072 || !mem_req) begin
                            errors++;
                            $display("FAIL stall_addr got %h want 0072",
                                     mem_addr);
                        end
                    end
                    mem_ready = 1'b1;
                end
            end
        join
        checks++;
        if (rd !== 8'h70 || cyc != 13) begin
            errors++;
            $display("FAIL stall_resp got %h/%0d want 70/13", rd, cyc);
        end
        checks++;
        if (xlog.size() != 4) begin
            errors++;
            $display("FAIL stall_beats got %0d want 4", xlog.size());
        end else begin
            checks++;
            if (xlog[2] !== {1'b0, 16'h0072, 8'h72}) begin
                errors++;
                $display("FAIL stall_beat2 got %h want 0007272", xlog[2]);
            end
        end
    endtask

    task automatic test_reset_mid_wback;
        logic [7:0] rd;
        int cyc, bursts, n;
        logic a2, b2;
        bit seen;
        cpu_op(1'b1, 16'h0051, 8'hCD, rd, cyc, a2, b2, bursts);
        checks++;
        if (cyc != 3 || bursts != 0) begin
            errors++;
            $display("FAIL dirty51 got %0d/%0d want 3/0", cyc, bursts);
        end
        @(negedge clock);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0010;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clock);
            n++;
            if (mem_req && mem_we && mem_addr == 16'h0052)
                seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wback_reach got 0 want 1");
        end
        reset   = 1'b0;
        cpu_req = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, cpu_ack, cpu_busy} !== 4'b0) begin
            errors++;
            $display("FAIL arst_ctl got %b want 0000",
                     {mem_req, mem_we, cpu_ack, cpu_busy});
        end
        checks++;
        if ({mem_addr, mem_wdata, cpu_rdata} !== 32'h0) begin
            errors++;
            $display("FAIL arst_data got %h want 0",
                     {mem_addr, mem_wdata, cpu_rdata});
        end
        @(negedge clock);
        reset = 1'b1;
        xlog.delete();
        cpu_op(1'b0, 16'h0010, 8'h00, rd, cyc, a2, b2, bursts);
        checks++;
        if (rd !== 8'h10 || cyc != 8 || bursts != 1) begin
            errors++;
            $display("FAIL reread got %h/%0d/%0d want 10/8/1",
                     rd, cyc, bursts);
        end
        checks++;
        if (xlog.size() != 4) begin
            errors++;
            $display("FAIL reread_beats got %0d want 4", xlog.size());
        end
`ifdef PERF_CNT_EN
        checks++;
        if (hit_cnt !== 16'd0 || miss_cnt !== 16'd1) begin
            errors++;
            $display("FAIL reread_cnt got %0d/%0d want 0/1",
                     hit_cnt, miss_cnt);
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int a = 0; a < 65536; a++)
            mem[a] = a[7:0];
        test_reset;
        test_read_miss;
        test_write_hit;
        test_perf;
        test_evict;
        test_stall;
        test_reset_mid_wback;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
